// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings and segment constants for the memory request arbiter
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE = 2'd0,
        MEM_ARB_REQ  = 2'd1,
        MEM_ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [3:0] KSEG0_HI    = 4'h8;
    localparam logic [3:0] KSEG1_HI    = 4'hB;
    localparam logic [3:0] UNCACHED_LO = 4'hA;

    function automatic logic seg_in(input logic [3:0] seg, input logic [3:0] lo, input logic [3:0] hi);
        return (seg >= lo) && (seg <= hi);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_addr_map.sv
// rtl/mem_req_arbiter_addr_map.sv - fixed kseg0/kseg1 virtual-to-physical translation
module mem_req_arbiter_addr_map
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] va,
    output logic [ADDR_W-1:0] pa,
    output logic              uncached
);

    logic [3:0] seg;
    logic       unmapped_seg;

    assign seg          = va[ADDR_W-1 -: 4];
    assign unmapped_seg = seg_in(seg, KSEG0_HI, KSEG1_HI);

    always_comb begin
        pa       = va;
        uncached = seg_in(seg, UNCACHED_LO, KSEG1_HI);
        if (unmapped_seg) begin
            pa = {3'b000, va[ADDR_W-4:0]};
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one memory bus between fetch and load/store ports, one transaction in flight
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed data-over-inst priority.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_uncached,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_e        state_q, state_d;
    arb_src_e          src_q, src_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic              uncached_q, uncached_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              grant_data;
    logic              grant_inst;
    logic [ADDR_W-1:0] win_va;
    logic [ADDR_W-1:0] win_pa;
    logic              win_uncached;

`ifdef MEM_ARB_RR_EN
    arb_src_e last_src_q, last_src_d;

    // With both ports asking, the one that lost last time wins; a lone requester always wins.
    assign grant_data = data_req && (!inst_req || (last_src_q == SRC_INST));

    always_comb begin
        last_src_d = last_src_q;
        if (cpu_rst_n && (state_q == MEM_ARB_IDLE) && (inst_req || data_req)) begin
            last_src_d = grant_data ? SRC_DATA : SRC_INST;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            last_src_q <= SRC_INST;
        end else begin
            last_src_q <= last_src_d;
        end
    end
`else
    assign grant_data = data_req;
`endif

    assign grant_inst = inst_req && !grant_data;
    assign win_va     = grant_data ? data_addr : inst_addr;

    mem_req_arbiter_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .va       (win_va),
        .pa       (win_pa),
        .uncached (win_uncached)
    );

    assign bus_req      = (state_q == MEM_ARB_REQ);
    assign bus_wr       = wr_q;
    assign bus_size     = size_q;
    assign bus_addr     = pa_q;
    assign bus_wdata    = wdata_q;
    assign bus_uncached = uncached_q;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        pa_d         = pa_q;
        uncached_d   = uncached_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;

        // Handshakes are suppressed while reset is low so nothing is accepted or completed then.
        if (cpu_rst_n) begin
            case (state_q)
                MEM_ARB_IDLE: begin
                    if (inst_req || data_req) begin
                        inst_addr_ok = grant_inst;
                        data_addr_ok = grant_data;
                        src_d        = grant_data ? SRC_DATA : SRC_INST;
                        pa_d         = win_pa;
                        uncached_d   = win_uncached;
                        wr_d         = grant_data ? data_wr : 1'b0;
                        size_d       = grant_data ? data_size : SIZE_W;
                        wdata_d      = grant_data ? data_wdata : '0;
                        state_d      = MEM_ARB_REQ;
                    end
                end
                MEM_ARB_REQ: begin
                    if (bus_addr_ok) begin
                        state_d = MEM_ARB_WAIT;
                    end
                end
                MEM_ARB_WAIT: begin
                    if (bus_data_ok) begin
                        if (src_q == SRC_DATA) begin
                            data_data_ok = 1'b1;
                            data_rdata   = bus_rdata;
                        end else begin
                            inst_data_ok = 1'b1;
                            inst_rdata   = bus_rdata;
                        end
                        state_d = MEM_ARB_IDLE;
                    end
                end
                default: begin
                    state_d = MEM_ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_q    <= MEM_ARB_IDLE;
            src_q      <= SRC_INST;
            pa_q       <= '0;
            uncached_q <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= SIZE_W;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            pa_q       <= pa_d;
            uncached_q <= uncached_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed vector bench for mem_req_arbiter (default fixed-priority build)
module tb_mem_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_uncached;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    mem_req_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst_n    (rst_n),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_uncached (bus_uncached),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [31:0] iaddr;
        logic        dwr;
        logic [1:0]  dsize;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        int          hold;
        logic        esrc;
        logic [31:0] eaddr;
        logic        eunc;
        logic        ewr;
        logic [1:0]  esize;
        logic [31:0] ewdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        inst_req    = v.ireq;
        inst_addr   = v.iaddr;
        data_req    = v.dreq;
        data_wr     = v.dwr;
        data_size   = v.dsize;
        data_addr   = v.daddr;
        data_wdata  = v.dwdata;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        #1;
        chk($sformatf("v%0d inst_addr_ok", idx), inst_addr_ok, v.esrc == 1'b0);
        chk($sformatf("v%0d data_addr_ok", idx), data_addr_ok, v.esrc == 1'b1);
        tick();
        for (int c = 0; c <= v.hold; c++) begin
            chk($sformatf("v%0d c%0d bus_req", idx, c), bus_req, 1);
            chk($sformatf("v%0d c%0d bus_addr", idx, c), bus_addr, v.eaddr);
            chk($sformatf("v%0d c%0d bus_uncached", idx, c), bus_uncached, v.eunc);
            chk($sformatf("v%0d c%0d bus_wr", idx, c), bus_wr, v.ewr);
            chk($sformatf("v%0d c%0d bus_size", idx, c), bus_size, v.esize);
            chk($sformatf("v%0d c%0d bus_wdata", idx, c), bus_wdata, v.ewdata);
            chk($sformatf("v%0d c%0d addr_ok quiet", idx, c), {inst_addr_ok, data_addr_ok}, 0);
            // A stray bus_data_ok while still requesting must be ignored.
            bus_data_ok = (c < v.hold);
            #1;
            chk($sformatf("v%0d c%0d data_ok quiet", idx, c), {inst_data_ok, data_data_ok}, 0);
            bus_data_ok = 1'b0;
            bus_addr_ok = (c == v.hold);
            tick();
        end
        bus_addr_ok = 1'b0;
        chk($sformatf("v%0d wait bus_req", idx), bus_req, 0);
        bus_rdata   = v.rdata;
        bus_data_ok = 1'b1;
        #1;
        chk($sformatf("v%0d inst_data_ok", idx), inst_data_ok, v.esrc == 1'b0);
        chk($sformatf("v%0d data_data_ok", idx), data_data_ok, v.esrc == 1'b1);
        chk($sformatf("v%0d rdata", idx), v.esrc ? data_rdata : inst_rdata, v.rdata);
        tick();
        bus_data_ok = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
    endtask

    initial begin
        //           ireq dreq iaddr         dwr dsz   daddr         dwdata        rdata         hold src eaddr         unc  wr  size  ewdata
        vecs[0]  = '{1'b1, 1'b0, 32'hBFC00000, 1'b0, 2'd2, 32'h0, 32'h0, 32'h3C08BFC0, 0, 1'b0, 32'h1FC00000, 1'b1, 1'b0, 2'd2, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0, 1'b1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0, 0, 1'b1, 32'h00001000, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0, 1'b0, 2'd0, 32'h00400000, 32'h0, 32'h11223344, 0, 1'b1, 32'h00400000, 1'b0, 1'b0, 2'd0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h9FC00010, 1'b0, 2'd0, 32'h0, 32'h0, 32'hCAFEF00D, 1, 1'b0, 32'h1FC00010, 1'b0, 1'b0, 2'd2, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0, 1'b0, 2'd1, 32'hA0000004, 32'h0, 32'h0000BEEF, 0, 1'b1, 32'h00000004, 1'b1, 1'b0, 2'd1, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0, 1'b1, 2'd2, 32'hC0000000, 32'h12345678, 32'h0, 0, 1'b1, 32'hC0000000, 1'b0, 1'b1, 2'd2, 32'h12345678};
        vecs[6]  = '{1'b1, 1'b0, 32'h7FFFFFFC, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0BADC0DE, 0, 1'b0, 32'h7FFFFFFC, 1'b0, 1'b0, 2'd2, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0, 1'b1, 2'd0, 32'hBFFFFFFF, 32'h000000A5, 32'h0, 0, 1'b1, 32'h1FFFFFFF, 1'b1, 1'b1, 2'd0, 32'h000000A5};
        vecs[8]  = '{1'b1, 1'b1, 32'h80000000, 1'b0, 2'd2, 32'h80000100, 32'h0, 32'hA1A1A1A1, 0, 1'b1, 32'h00000100, 1'b0, 1'b0, 2'd2, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h80000000, 1'b1, 2'd2, 32'hA0000200, 32'h55AA55AA, 32'h0, 5, 1'b1, 32'h00000200, 1'b1, 1'b1, 2'd2, 32'h55AA55AA};
        vecs[10] = '{1'b1, 1'b1, 32'h80000000, 1'b0, 2'd1, 32'h00000302, 32'h0, 32'hB2B2B2B2, 0, 1'b1, 32'h00000302, 1'b0, 1'b0, 2'd1, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h80000000, 1'b0, 2'd2, 32'h90000400, 32'h0, 32'hC3C3C3C3, 2, 1'b1, 32'h10000400, 1'b0, 1'b0, 2'd2, 32'h0};

        rst_n       = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC00000;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'd0;
        data_addr   = 32'h80001000;
        data_wdata  = 32'hFFFFFFFF;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        for (int r = 0; r < 3; r++) begin
            tick();
            chk($sformatf("rst%0d bus_req", r), bus_req, 0);
            chk($sformatf("rst%0d addr_ok", r), {inst_addr_ok, data_addr_ok}, 0);
            chk($sformatf("rst%0d data_ok", r), {inst_data_ok, data_data_ok}, 0);
            chk($sformatf("rst%0d bus_addr", r), bus_addr, 0);
            chk($sformatf("rst%0d bus_wr", r), bus_wr, 0);
            chk($sformatf("rst%0d bus_size", r), bus_size, 2);
        end
        rst_n    = 1'b1;
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();

        // bus_data_ok in IDLE has nothing to complete.
        bus_data_ok = 1'b1;
        #1;
        chk("idle stray data_ok", {inst_data_ok, data_data_ok}, 0);
        bus_data_ok = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset while waiting for the response drops the transaction.
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h80002000;
        #1;
        chk("rstwait grant", data_addr_ok, 1);
        tick();
        data_req    = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        chk("rstwait in wait", bus_req, 0);
        rst_n       = 1'b0;
        bus_rdata   = 32'h77777777;
        bus_data_ok = 1'b1;
        #1;
        chk("rstwait no data_ok during rst", {inst_data_ok, data_data_ok}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstwait no data_ok after rst", {inst_data_ok, data_data_ok}, 0);
        chk("rstwait bus_req", bus_req, 0);
        chk("rstwait bus_addr cleared", bus_addr, 0);
        bus_data_ok = 1'b0;
        tick();
        run_txn(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
